// File: rtl/axis_loopback_fifo.sv
// AXI4-Stream loopback buffer: beats taken on the slave port are replayed in order
// on the master port through a DEPTH-entry first-word-fall-through FIFO.
module axis_loopback_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    input  logic                  flush,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic [15:0]           pkt_count
);

    localparam int PTR_WIDTH = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = PTR_WIDTH'(DEPTH);

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH:0] rd_ptr_reg, rd_ptr_next;
    logic [15:0]         pkt_count_reg, pkt_count_next;
    logic                push;
    logic                pop;

    // Status comes only from the pointer registers, never from the handshake inputs.
    assign count         = wr_ptr_reg - rd_ptr_reg;
    assign full          = (count == FULL_COUNT);
    assign empty         = (count == '0);
    assign s_axis_tready = rst & ~full;
    assign m_axis_tvalid = ~empty;
    assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
    assign pkt_count     = pkt_count_reg;

    assign push = s_axis_tvalid & s_axis_tready & ~flush;
    assign pop  = m_axis_tvalid & m_axis_tready & ~flush;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        pkt_count_next = pkt_count_reg;
        if (flush) begin
            wr_ptr_next = rd_ptr_reg;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_WIDTH'(1);
                if (m_axis_tlast) begin
                    pkt_count_next = pkt_count_reg + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            pkt_count_reg <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            pkt_count_reg <= pkt_count_next;
        end
    end

    // Storage is left unreset so it can map onto memory primitives.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

endmodule

// File: tb/tb_axis_loopback_fifo.sv
// Bench for axis_loopback_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized streaming run.
module tb_axis_loopback_fifo;

    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int NBEATS = 1000;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          flush;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic [15:0]   pkt_count;

    always #5 clk = ~clk;

    axis_loopback_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .flush        (flush),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .pkt_count    (pkt_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered queue of {tlast, tdata} plus a packet counter.
    logic [DW:0] q[$];
    logic [15:0] m_pkt = '0;
    int          m_pops = 0;
    bit          m_do_pop, m_do_push;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                m_pkt  = '0;
                m_pops = 0;
            end else if (flush) begin
                q.delete();
            end else begin
                m_do_pop  = (q.size() > 0) && m_axis_tready;
                m_do_push = (q.size() < DEPTH) && s_axis_tvalid;
                if (m_do_pop) begin
                    if (q[0][DW]) m_pkt = m_pkt + 16'd1;
                    void'(q.pop_front());
                    m_pops++;
                end
                if (m_do_push) q.push_back({s_axis_tlast, s_axis_tdata});
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("tready", 32'(s_axis_tready), 32'(rst && (q.size() < DEPTH)));
            check("tvalid", 32'(m_axis_tvalid), 32'(q.size() > 0));
            check("count",  32'(count),         32'(q.size()));
            check("full",   32'(full),          32'(q.size() == DEPTH));
            check("empty",  32'(empty),         32'(q.size() == 0));
            check("pkt",    32'(pkt_count),     32'(m_pkt));
            if (rst && q.size() > 0)
                check("head", 32'({m_axis_tlast, m_axis_tdata}), 32'(q[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] sd [NBEATS];
    int  idx, out_idx, cyc;
    bit  acc;

    initial begin
        rst = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0; flush = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("tready_after_rst", 32'(s_axis_tready), 32'd1);

        // Single beat
        s_axis_tdata = 8'hA5; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        #1;
        check("no_bypass", 32'(m_axis_tvalid), 32'd0);
        step();
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        check("t1_valid", 32'(m_axis_tvalid), 32'd1);
        check("t1_data",  32'(m_axis_tdata),  32'h0A5);
        check("t1_last",  32'(m_axis_tlast),  32'd1);
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        check("t1_pkt",   32'(pkt_count), 32'd1);
        check("t1_empty", 32'(empty),     32'd1);

        // Fill to full with output stalled
        idx = 0;
        for (int c = 0; c < 24; c++) begin
            s_axis_tvalid = (idx < 20);
            s_axis_tdata  = DW'(idx);
            acc = s_axis_tvalid && s_axis_tready;
            step();
            if (acc) idx++;
        end
        check("fill_accepted", 32'(idx),           32'd16);
        check("fill_count",    32'(count),         32'd16);
        check("fill_full",     32'(full),          32'd1);
        check("fill_tready",   32'(s_axis_tready), 32'd0);
        check("fill_head",     32'(m_axis_tdata),  32'h00);

        // Full with a simultaneous pop: source keeps offering 0x10
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        check("fullpop_count",  32'(count),         32'd15);
        check("fullpop_tready", 32'(s_axis_tready), 32'd1);

        m_axis_tready = 1'b1;
        for (int k = 1; k < 16; k++) begin
            check("drain_data", 32'(m_axis_tdata), 32'(k));
            step();
        end
        m_axis_tready = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);

        // Flush with pending output
        for (int k = 0; k < 5; k++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = DW'(8'h20 + k);
            step();
        end
        check("pre_flush_count", 32'(count), 32'd5);
        flush = 1'b1; s_axis_tdata = 8'h77; s_axis_tlast = 1'b1;
        step();
        flush = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        check("flush_count", 32'(count),         32'd0);
        check("flush_valid", 32'(m_axis_tvalid), 32'd0);
        check("flush_pkt",   32'(pkt_count),     32'd1);
        step();
        check("flush_not_stored", 32'(empty), 32'd1);
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'h3C;
        step();
        s_axis_tvalid = 1'b0;
        check("post_flush_data", 32'(m_axis_tdata), 32'h3C);
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;

        // Reset mid-stream at count 9, asserted between clock edges
        for (int k = 0; k < 9; k++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = DW'(8'h40 + k);
            step();
        end
        s_axis_tvalid = 1'b0;
        check("pre_rst_count", 32'(count), 32'd9);
        #2;
        rst = 1'b0;
        #1;
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_count",  32'(count),         32'd0);
        check("rst_full",   32'(full),          32'd0);
        check("rst_empty",  32'(empty),         32'd1);
        check("rst_pkt",    32'(pkt_count),     32'd0);
        step(); step();
        rst = 1'b1;
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'h5A; s_axis_tlast = 1'b1;
        step();
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        check("post_rst_data",  32'(m_axis_tdata), 32'h5A);
        check("post_rst_count", 32'(count),        32'd1);

        // Randomized streaming after a fresh reset
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        for (int i = 0; i < NBEATS; i++) sd[i] = DW'($urandom);
        idx = 0; out_idx = 0; cyc = 0;
        while ((idx < NBEATS || m_pops < NBEATS) && cyc < 20000) begin
            if (idx < NBEATS) begin
                if (!s_axis_tvalid) s_axis_tvalid = ($urandom_range(0, 9) < 7);
                s_axis_tdata = sd[idx];
                s_axis_tlast = (idx % 7 == 6);
            end else begin
                s_axis_tvalid = 1'b0;
            end
            m_axis_tready = ($urandom_range(0, 9) < 6);
            #1;
            acc = s_axis_tvalid && s_axis_tready;
            if (m_axis_tvalid && m_axis_tready) begin
                if (out_idx < NBEATS)
                    check("stream_beat", 32'({m_axis_tlast, m_axis_tdata}),
                          32'({out_idx % 7 == 6, sd[out_idx]}));
                out_idx++;
            end
            step();
            if (acc) begin
                idx++;
                s_axis_tvalid = 1'b0;
            end
            cyc++;
        end
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        check("stream_in_time", 32'(cyc < 20000), 32'd1);
        check("stream_out_n",   32'(out_idx),     32'(NBEATS));
        check("model_pops",     32'(m_pops),      32'(NBEATS));
        check("stream_pkt",     32'(pkt_count),   32'd142);
        check("stream_empty",   32'(empty),       32'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
